serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences one instance of the team's single-bit `full_adder` cell to add two WIDTH-bit operands plus a carry-in, LSB first, one bit per clock. It trades WIDTH cycles of latency for a datapath of one full adder, a carry flip-flop and three shift registers. It is the first sequential consumer of the combinational adder cell. It sits wherever a small-area adder with a start/done handshake is acceptable.

---
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell, LSB first, one bit per clock.
// Latency WIDTH+1 cycles from start to done; start is ignored while busy.
// Backpressure: none, so the consumer must take sum/cout in the done cycle.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic             cy;
   logic             cout_q;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_step;

   full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (cy),
      .s  (fa_s),
      .co (fa_c)
   );

   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (last_step) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cout is a separate flop so it holds the previous result while the
   // next start reloads cy with the new carry-in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         s_sr   <= '0;
         cy     <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  cy   <= cin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               s_sr   <= {fa_s, s_sr[WIDTH-1:1]};
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               cy     <= fa_c;
               cout_q <= fa_c;
               cnt    <= cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign sum  = s_sr;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for vectors and
// corner sequences, a 4-bit instance for the exhaustive back-to-back sweep.
module tb_serial_adder_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start8;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start4;
   logic [3:0] a4, b4;
   logic       cin4;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int tests = 0;
   int fails = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pulse start for one edge, then expect busy until done at the 9th
   // sample after the accepting edge, then idle with the result held.
   task automatic run_op8(input vec_t v, input string name);
      int n;
      @(negedge clk);
      start8 = 1'b1; a8 = v.a; b8 = v.b; cin8 = v.cin;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
      n = 1;
      while (!done8 && n < 20) begin
         check({name, " busy_run"}, {31'd0, busy8}, 32'd1);
         @(negedge clk);
         n++;
      end
      check({name, " latency"}, n, 32'd9);
      check({name, " sum"}, {24'd0, sum8}, {24'd0, v.exp_sum});
      check({name, " cout"}, {31'd0, cout8}, {31'd0, v.exp_cout});
      check({name, " busy_done"}, {31'd0, busy8}, 32'd1);
      @(negedge clk);
      check({name, " after_done"}, {30'd0, busy8, done8}, 32'd0);
      check({name, " sum_hold"}, {23'd0, cout8, sum8}, {23'd0, v.exp_cout, v.exp_sum});
   endtask

   logic [4:0] exp_q[$];

   initial begin
      int n;
      int ndone;
      vec_t v;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

      // reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("reset_idle", {21'd0, busy8, done8, cout8, sum8}, 32'd0);
         @(negedge clk);
      end

      for (int i = 0; i < 8; i++) run_op8(vecs[i], $sformatf("vec%0d", i));

      // start while busy: re-requests at E3 and in the DONE cycle are ignored
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 20) begin
         if (n == 2) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      check("busy_start latency", n, 32'd9);
      check("busy_start sum", {23'd0, cout8, sum8}, 32'h010);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) ndone++;
         @(negedge clk);
      end
      check("busy_start no_second_op", ndone, 32'd0);
      check("busy_start sum_hold", {23'd0, cout8, sum8}, 32'h010);

      // reset mid-operation at E4
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset state", {21'd0, busy8, done8, cout8, sum8}, 32'd0);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) ndone++;
         @(negedge clk);
      end
      check("midreset no_done", ndone, 32'd0);
      v = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      run_op8(v, "post_reset");

      // exhaustive WIDTH=4, start held high, accepted every 6 edges
      fork
         begin
            for (int k = 0; k < 512; k++) begin
               logic [3:0] ka, kb;
               logic       kc;
               ka = k[8:5]; kb = k[4:1]; kc = k[0];
               @(negedge clk);
               start4 = 1'b1; a4 = ka; b4 = kb; cin4 = kc;
               exp_q.push_back({1'b0, ka} + {1'b0, kb} + {4'd0, kc});
               repeat (6) @(posedge clk);
            end
            @(negedge clk);
            start4 = 1'b0;
         end
         begin
            int last;
            int cnt4;
            logic [4:0] e;
            last = -1;
            cnt4 = 0;
            for (int cyc = 0; cyc < 512 * 6 + 40; cyc++) begin
               @(negedge clk);
               if (done4) begin
                  if (exp_q.size() == 0) begin
                     check("exh spurious_done", 32'd1, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check($sformatf("exh op%0d result", cnt4), {27'd0, cout4, sum4}, {27'd0, e});
                  end
                  if (last >= 0) check($sformatf("exh op%0d spacing", cnt4), cyc - last, 32'd6);
                  last = cyc;
                  cnt4++;
               end
            end
            check("exh done_count", cnt4, 32'd512);
         end
      join
      check("exh queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
